// File: rtl/multicycle_pkg.sv
// Shared encodings for the reduced RISC-V multicycle controller: FSM states,
// opcodes, ALU operations and the mux-select codes the datapath blocks decode.
// Ports: none (package only).
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  // Which ALU decode rule applies in the current state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_SUB = 2'd1,
    ALU_CLS_R   = 2'd2,
    ALU_CLS_I   = 2'd3
  } alu_cls_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps (op_class, funct3, funct7[5]) to alu_control.
// Ports: op_class_i, funct3_i, funct7_5_i in; alu_control_o out.
// Purely combinational; funct7[5] only selects sub for register-register ops.
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_cls_e   op_class_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (op_class_i)
      ALU_CLS_ADD: alu_control_o = ALU_ADD;
      ALU_CLS_SUB: alu_control_o = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3_i)
          // addi has no subtract form, so funct7[5] is only honoured for OP
          3'b000:  alu_control_o = (op_class_i == ALU_CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b010:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the reduced RISC-V multicycle datapath (lw, sw, OP,
// OP-IMM, beq, bne). Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
// Ports: clk, rst (sync, active-high), instr, zero, mem_ready in; datapath
// enables/selects, alu_control, imm_src, state_o and illegal out.
// Build option MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a
// sticky ERROR state; otherwise they retire as a NOP.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_control,
  output logic [1:0]            imm_src,
  output logic [3:0]            state_o,
  output logic                  illegal
);

  state_e     state_q, state_d;
  state_e     cur_state;
  alu_cls_e   alu_cls;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  // While rst is high the outputs present FETCH, so the datapath sees a
  // clean fetch setup and no stale write from an abandoned instruction.
  assign cur_state = rst ? S_FETCH : state_q;
  assign state_o   = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    alu_cls       = ALU_CLS_ADD;

    case (cur_state)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= oldPC + B-immediate, ready for a taken branch
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP_IMM:          state_d = S_EXECI;
          OPC_OP:              state_d = S_EXECR;
          OPC_BRANCH:          state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:             state_d = S_ERROR;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_RDATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        // strobe and address stay steady across the whole stall
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_cls   = ALU_CLS_R;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_cls   = ALU_CLS_I;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_cls    = ALU_CLS_SUB;
        result_src = RES_ALUOUT;
        // beq/bne only; funct3[0] inverts the sense of the zero flag
        pc_write_raw = (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
        state_d      = S_FETCH;
      end
      S_ERROR: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        state_d = S_ERROR;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write  = pc_write_raw  & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_d == S_ERROR) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q & ~rst;
`else
  assign illegal = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .op_class_i    (alu_cls),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7_5),
    .alu_control_o (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected output
// traces are built from the instruction class and the planned stall counts,
// then replayed cycle by cycle against the DUT.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state_o;
  logic        illegal;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, regw, memw, adr;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic mr;
    logic z;
  } step_t;

  step_t q[$];

  multicycle_control #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t observed();
    return {state_o, pc_write, ir_write, reg_write, mem_write, adr_src,
            result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};
  endfunction

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // ALU op for arithmetic instructions, straight from the funct3 table.
  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input exp_t e, input logic mr, input logic z);
    step_t s;
    s.e = e; s.mr = mr; s.z = z;
    q.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // zsel: 0/1 forces the zero flag, 2 randomizes it.
  task automatic gen_instr(input logic [31:0] ins, input int fs, input int ms, input int zsel);
    exp_t e;
    logic z;
    logic [2:0] f3;
    f3 = ins[14:12];
    for (int k = 0; k <= fs; k++) begin
      e = mk(4'd0);
      e.pcw = (k == fs); e.irw = (k == fs); e.b = 2'b10; e.rs = 2'b10;
      push(e, (k == fs), rbit());
    end
    e = mk(4'd1); e.a = 2'b01; e.b = 2'b01; e.imm = 2'b10;
    push(e, rbit(), rbit());
    case (ins[6:0])
      7'b0000011: begin
        e = mk(4'd2); e.a = 2'b10; e.b = 2'b01; push(e, rbit(), rbit());
        for (int k = 0; k <= ms; k++) begin
          e = mk(4'd3); e.adr = 1'b1; push(e, (k == ms), rbit());
        end
        e = mk(4'd4); e.rs = 2'b01; e.regw = 1'b1; push(e, rbit(), rbit());
      end
      7'b0100011: begin
        e = mk(4'd2); e.a = 2'b10; e.b = 2'b01; e.imm = 2'b01; push(e, rbit(), rbit());
        for (int k = 0; k <= ms; k++) begin
          e = mk(4'd5); e.adr = 1'b1; e.memw = 1'b1; push(e, (k == ms), rbit());
        end
      end
      7'b0110011: begin
        e = mk(4'd6); e.a = 2'b10; e.alu = alu_ref(f3, ins[30], 1'b1); push(e, rbit(), rbit());
        e = mk(4'd8); e.regw = 1'b1; push(e, rbit(), rbit());
      end
      7'b0010011: begin
        e = mk(4'd7); e.a = 2'b10; e.b = 2'b01; e.alu = alu_ref(f3, ins[30], 1'b0);
        push(e, rbit(), rbit());
        e = mk(4'd8); e.regw = 1'b1; push(e, rbit(), rbit());
      end
      7'b1100011: begin
        z = (zsel == 2) ? rbit() : (zsel == 1);
        e = mk(4'd9); e.a = 2'b10; e.alu = 3'b001;
        e.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
        push(e, rbit(), z);
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) begin
          e = mk(4'd10); e.ill = 1'b1; push(e, rbit(), rbit());
        end
`endif
      end
    endcase
  endtask

  // Called just after a rising edge; replays up to n queued cycles.
  task automatic run_queue(input int n);
    step_t s;
    int done;
    done = 0;
    while (q.size() > 0 && done < n) begin
      s = q.pop_front();
      mem_ready = s.mr;
      zero      = s.z;
      #1;
      check_eq($sformatf("trace st%0d", s.e.st), 32'(observed()), 32'(s.e));
      @(posedge clk); #1;
      done++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("rst state", 32'(state_o), 32'd0);
      check_eq("rst enables", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
      check_eq("rst illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_eq("post-rst ir_write", 32'(ir_write), 32'd1);
    check_eq("post-rst pc_write", 32'(pc_write), 32'd1);
    check_eq("post-rst illegal", 32'(illegal), 32'd0);
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0010011 ||
           op == 7'b0110011 || op == 7'b1100011;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int kind;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    kind = $urandom_range(0, 4);
`else
    kind = $urandom_range(0, 5);
`endif
    ins = $urandom;
    case (kind)
      0: ins[6:0] = 7'b0000011;
      1: ins[6:0] = 7'b0100011;
      2: ins[6:0] = 7'b0110011;
      3: ins[6:0] = 7'b0010011;
      4: begin ins[6:0] = 7'b1100011; ins[13] = rbit() & rbit(); end
      default: while (is_legal(ins[6:0])) ins[6:0] = 7'($urandom);
    endcase
    return ins;
  endfunction

  function automatic int rstall();
    return rbit() ? 0 : $urandom_range(1, 3);
  endfunction

  initial begin
    instr = 32'd0;
    do_reset();

    // addi x1,x0,5
    instr = 32'h00500093; gen_instr(instr, 0, 0, 2); run_queue(1000);
    // lw x2,0(x0) with two MEMREAD stall cycles
    instr = 32'h00002103; gen_instr(instr, 0, 2, 2); run_queue(1000);
    // sw x2,4(x0) with fetch and write stalls
    instr = 32'h00202223; gen_instr(instr, 1, 2, 2); run_queue(1000);
    // beq taken, bne not taken, bne taken
    instr = 32'h00000063; gen_instr(instr, 0, 0, 1); run_queue(1000);
    instr = 32'h00001063; gen_instr(instr, 0, 0, 1); run_queue(1000);
    instr = 32'h00001063; gen_instr(instr, 0, 0, 0); run_queue(1000);
    // sub x3,x1,x2
    instr = 32'h402081B3; gen_instr(instr, 0, 0, 2); run_queue(1000);

    for (int i = 0; i < 80; i++) begin
      instr = rand_instr();
      gen_instr(instr, rstall(), rstall(), 2);
      run_queue(1000);
    end

    // Reset in the middle of a stalled store: no write may leak out.
    instr = 32'h00202223; gen_instr(instr, 0, 3, 2); run_queue(4);
    q.delete();
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check_eq("midrst mem_write", 32'(mem_write), 32'd0);
    check_eq("midrst state", 32'(state_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check_eq("after midrst state", 32'(state_o), 32'd0);
    check_eq("after midrst mem_write", 32'(mem_write), 32'd0);
    do_reset();

    // Unknown opcode 0x7F: trap (held until reset) or NOP.
    instr = 32'h0000007F; gen_instr(instr, 0, 0, 2); run_queue(1000);
    mem_ready = 1'b1;
    #1;
    check_eq("after 7F state", 32'(state_o),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
             32'd10);
`else
             32'd0);
`endif
    @(posedge clk); #1;
    do_reset();
    instr = 32'h00500093; gen_instr(instr, 0, 0, 2); run_queue(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
